// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the convolution-layer DMA arbiter.
// Holds the FSM state type, DMA widths and requester IDs.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int DMA_ADDR_W = 16;
    localparam int DMA_DATA_W = 16;

    localparam int REQ_LOAD  = 0;
    localparam int REQ_WRITE = 1;
    localparam int REQ_PREV  = 2;

    // Index width that stays legal when there is a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_arbiter_rr_picker.sv
// Round-robin picker: first set request after rr_ptr, with wrap.
// Ports: req_i (requests), rr_ptr_i (last winner), winner_o, valid_o.
module rr_picker
    import dma_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   rr_ptr_i,
    output logic [IDW-1:0]   winner_o,
    output logic             valid_o
);

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_i) + k) % N_REQ;
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// Lock-held round-robin arbiter sharing one DMA port between requesters.
// Ports: clk, reset (sync, active-high); req/req_rw/req_addr/req_wdata in;
// grant, owner_id, busy, dma_en/rw/addr/wdata, timeout out.
// Optional macro DMA_ARB_TIMEOUT_EN bounds ownership to HOLD_MAX cycles.
module dma_arbiter
    import dma_arb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = DMA_ADDR_W,
    parameter int DATA_W   = DMA_DATA_W,
    parameter int HOLD_MAX = 64,
    parameter int IDW      = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_rw,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        grant,
    output logic [IDW-1:0]          owner_id,
    output logic                    busy,
    output logic                    dma_en,
    output logic                    dma_rw,
    output logic [ADDR_W-1:0]       dma_addr,
    output logic [DATA_W-1:0]       dma_wdata,
    output logic [N_REQ-1:0]        timeout
);

    arb_state_t       state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IDW-1:0]   owner_q;
    logic [IDW-1:0]   ptr_q;
    logic             busy_q;
    logic [IDW-1:0]   win_d;
    logic             win_vld_d;

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int HCW = $clog2(HOLD_MAX) + 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);
    logic [HCW-1:0]   hold_q;
    logic [N_REQ-1:0] timeout_q;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_i    (req),
        .rr_ptr_i (ptr_q),
        .winner_o (win_d),
        .valid_o  (win_vld_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= IDW'(N_REQ - 1);
            busy_q  <= 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= '0;
`endif
        end else begin
`ifdef DMA_ARB_TIMEOUT_EN
            timeout_q <= '0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        state_q <= GRANT;
                        grant_q <= N_REQ'(1) << win_d;
                        owner_q <= win_d;
                        ptr_q   <= win_d;
                        busy_q  <= 1'b1;
`ifdef DMA_ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!req[owner_q]) begin
                        state_q <= GAP;
                        grant_q <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
                    end else if (hold_q == HOLD_LAST) begin
                        // Forced release; requester re-arbitrates in IDLE.
                        state_q            <= GAP;
                        grant_q            <= '0;
                        timeout_q[owner_q] <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
`endif
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign owner_id = owner_q;
    assign busy     = busy_q;

    // Enable follows the owner's request so a release edge issues no access.
    assign dma_en    = (state_q == GRANT) && req[owner_q];
    assign dma_rw    = req_rw[owner_q];
    assign dma_addr  = req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
    assign dma_wdata = req_wdata[int'(owner_q)*DATA_W +: DATA_W];

`ifdef DMA_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = '0;
`endif

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed + randomized bench for dma_arbiter against a cycle reference model.
module tb_dma_arbiter;
    import dma_arb_pkg::*;

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int HOLD = 4;
    localparam bit TO_ON = 1'b1;
`else
    localparam int HOLD = 64;
    localparam bit TO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  rw;
    logic [15:0] a [3];
    logic [15:0] w [3];
    logic [47:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  grant;
    logic [1:0]  owner_id;
    logic        busy, dma_en, dma_rw;
    logic [15:0] dma_addr, dma_wdata;
    logic [2:0]  timeout;

    assign req_addr  = {a[2], a[1], a[0]};
    assign req_wdata = {w[2], w[1], w[0]};

    always #5 clk = ~clk;

    dma_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_rw    (rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .grant     (grant),
        .owner_id  (owner_id),
        .busy      (busy),
        .dma_en    (dma_en),
        .dma_rw    (dma_rw),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .timeout   (timeout)
    );

    int checks = 0;
    int failures = 0;

    // Reference: who owns the port, whether we are in the turnaround
    // cycle, and who won last (round-robin starting point).
    bit       m_owning, m_turn;
    int       m_owner, m_last, m_held;
    logic [2:0] m_to;
    bit       auto_drop;
    int       own_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] eg;
        eg = m_owning ? (3'b001 << m_owner) : 3'b000;
        chk({tag, ":grant"}, 32'(grant), 32'(eg));
        chk({tag, ":owner"}, 32'(owner_id), 32'(m_owner));
        chk({tag, ":busy"}, 32'(busy), 32'(m_owning || m_turn));
        chk({tag, ":en"}, 32'(dma_en), 32'(m_owning && req[m_owner]));
        chk({tag, ":rw"}, 32'(dma_rw), 32'(rw[m_owner]));
        chk({tag, ":addr"}, 32'(dma_addr), 32'(a[m_owner]));
        chk({tag, ":wdata"}, 32'(dma_wdata), 32'(w[m_owner]));
        chk({tag, ":timeout"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic model_edge();
        m_to = 3'b000;
        if (reset) begin
            m_owning = 0; m_turn = 0;
            m_owner = 0; m_last = 2; m_held = 0;
        end else if (m_turn) begin
            m_turn = 0;
        end else if (m_owning) begin
            if (!req[m_owner] || (TO_ON && m_held == HOLD - 1)) begin
                if (req[m_owner]) m_to[m_owner] = 1'b1;
                m_owning = 0; m_turn = 1;
            end else begin
                m_held++;
            end
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (!m_owning && req[c]) begin
                    m_owning = 1; m_owner = c; m_last = c; m_held = 0;
                end
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
        own_cnt = m_owning ? own_cnt + 1 : 0;
        if (auto_drop && own_cnt > 3) req[m_owner] = 1'b0;
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        reset = 1; req = 0; rw = 0; auto_drop = 0; own_cnt = 0;
        for (int i = 0; i < 3; i++) begin a[i] = 0; w[i] = 0; end
        @(posedge clk);
        model_edge();
        #1;
        step("reset");
        reset = 0;
        step("idle");

        a[REQ_LOAD] = 16'd200; rw[REQ_LOAD] = 1'b1; req = 3'b001;
        steps("single", 6);
        req = 3'b000;
        steps("single_rel", 3);

        auto_drop = 1;
        for (int r = 0; r < 2; r++) begin
            req = 3'b111;
            steps("rr", 16);
        end
        auto_drop = 0;

        a[REQ_WRITE] = 16'd512; w[REQ_WRITE] = 16'hFFF6;
        rw[REQ_WRITE] = 1'b0; req = 3'b010;
        steps("wr_arb", 2);
        for (int i = 0; i < 6; i++) begin
            req[REQ_LOAD] = ~req[REQ_LOAD];
            step("wr_hold");
        end
        req = 3'b001;
        steps("wr_rel", 6);
        req = 3'b000;
        steps("wr_idle", 3);

        req = 3'b100;
        steps("rst_mid", 2);
        req = 3'b111; reset = 1;
        step("rst_edge");
        reset = 0; auto_drop = 1;
        steps("rst_after", 14);
        auto_drop = 0; req = 0;
        steps("rst_idle", 3);

        req = 3'b001;
        steps("pulse_own", 2);
        req = 3'b011;
        step("pulse");
        req = 3'b001;
        steps("pulse_after", 3);
        req = 3'b000;
        steps("pulse_idle", 4);

`ifdef DMA_ARB_TIMEOUT_EN
        req = 3'b011;
        steps("tmo", 14);
        req = 3'b000;
        steps("tmo_idle", 4);
`endif

        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(0, 5) == 0) req[j] = ~req[j];
                rw[j] = 1'($urandom);
                a[j]  = 16'($urandom);
                w[j]  = 16'($urandom);
            end
            reset = ($urandom_range(0, 63) == 0);
            step("rand");
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
